gelato_l1_icache: RTL and testbench

Responder end of the instruction-fetch cache interface. It accepts word-aligned fetch addresses from the I-Fetch unit and returns one 32-bit instruction word per request. The cache is direct-mapped and blocking, so only one request is outstanding at a time. Misses are refilled from the L2/memory side with a fixed-length line burst.

---
 rtl/gelato_l1_icache.sv | 171 +++++++++++++++++
 tb/tb_gelato_l1_icache.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_l1_icache.sv
// Direct-mapped, blocking L1 instruction cache with a fixed-length line refill.
// Define GELATO_ICACHE_FLUSH_EN to add a flush input that invalidates every line.
`timescale 1ns/1ps
module gelato_l1_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
`ifdef GELATO_ICACHE_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int DEPTH = NUM_LINES * LINE_WORDS;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESPOND
    } state_t;

    state_t                 state;
    logic [TAG_W-1:0]       tag_q;
    logic [IDX_W-1:0]       idx_q;
    logic [OFF_W-1:0]       off_q;
    logic [OFF_W-1:0]       beat;
    logic [NUM_LINES-1:0]   valid_bits;
    logic                   req_ready_q;

    logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];

    logic                   lookup_hit;
    logic                   last_beat;
    logic                   flush_now;
    logic [DATA_WIDTH-1:0]  read_word;

    // Byte-lane bits of the fetch address carry no information for word fetches.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    assign lookup_hit = valid_bits[idx_q] && (tag_mem[idx_q] == tag_q);
    assign last_beat  = (beat == LAST_BEAT);
    assign read_word  = data_mem[{idx_q, off_q}];

`ifdef GELATO_ICACHE_FLUSH_EN
    logic flush_pend;
    // A flush cycle in IDLE blocks the accept, so ready is masked while one is due.
    assign flush_now = (state == IDLE) && (flush || flush_pend);
    assign req_ready = req_ready_q && !(flush || flush_pend);
`else
    assign flush_now = 1'b0;
    assign req_ready = req_ready_q;
`endif

    // Line storage carries no reset; only the valid bits decide whether it is trusted.
    always_ff @(posedge clk) begin
        if (rdy && (state == REFILL) && mem_resp_valid) begin
            data_mem[{idx_q, beat}] <= mem_resp_data;
            if (last_beat) begin
                tag_mem[idx_q] <= tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tag_q         <= '0;
            idx_q         <= '0;
            off_q         <= '0;
            beat          <= '0;
            valid_bits    <= '0;
            req_ready_q   <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
`ifdef GELATO_ICACHE_FLUSH_EN
            flush_pend    <= 1'b0;
`endif
        end else if (rdy) begin
            resp_valid <= 1'b0;
`ifdef GELATO_ICACHE_FLUSH_EN
            if (flush && (state != IDLE)) begin
                flush_pend <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (flush_now) begin
                        valid_bits <= '0;
`ifdef GELATO_ICACHE_FLUSH_EN
                        flush_pend <= 1'b0;
`endif
                    end else if (req_valid) begin
                        tag_q       <= req_addr[ADDR_WIDTH-1 -: TAG_W];
                        idx_q       <= req_addr[2+OFF_W +: IDX_W];
                        off_q       <= req_addr[2 +: OFF_W];
                        req_ready_q <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        resp_valid  <= 1'b1;
                        resp_data   <= read_word;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {tag_q, idx_q, {(OFF_W+2){1'b0}}};
                        state         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= '0;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_resp_valid) begin
                        if (last_beat) begin
                            valid_bits[idx_q] <= 1'b1;
                            beat              <= '0;
                            state             <= RESPOND;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    resp_valid  <= 1'b1;
                    resp_data   <= read_word;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
`ifndef SYNTHESIS
                    $fatal(1, "gelato_l1_icache: illegal state %0d", state);
`endif
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gelato_l1_icache.sv
// Scoreboard bench for gelato_l1_icache: every fetch must return the backing-memory word,
// with refill traffic predicted by a simple valid/tag model of a 64x4-word direct-mapped cache.
`timescale 1ns/1ps
module tb_gelato_l1_icache;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef GELATO_ICACHE_FLUSH_EN
    logic        flush;
`endif

    gelato_l1_icache dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
`ifdef GELATO_ICACHE_FLUSH_EN
        .flush         (flush),
`endif
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_count = 0;
    int resp_cyc = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] exp_word;
    bit          mvalid [64];
    int unsigned mtag   [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backing memory: explicit entries for the directed lines, a hash everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        if (mem_store.exists(k)) return mem_store[k];
        return (k * 32'h9E37_79B1) ^ 32'h5EED_0000;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check_output("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_output("rst_resp_data", resp_data, 32'd0);
        check_output("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check_output("rst_mem_req_addr", mem_req_addr, 32'd0);
    endtask

    // Monitor: each response pulse (counted once per enabled cycle) pops the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rdy && resp_valid) begin
            resp_cyc = cyc;
            resp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: actual 0x%08h, required no response", resp_data);
            end else begin
                exp_word = exp_q.pop_front();
                check_output("resp_data", resp_data, exp_word);
            end
        end
    end

    // One fetch, playing the memory side for any refill the model predicts.
    task automatic apply_stimulus(input logic [31:0] addr, input int req_stall,
                                  input int stall_beat, input int reset_beat, input int flush_beat);
        logic [31:0] line_addr;
        int unsigned idx, tag;
        bit hit, ok, saw_mreq;
        int n, base, drive_cyc, beat_cyc;
        line_addr = addr & ~32'hF;
        idx = (addr / 16) % 64;
        tag = addr / 1024;
        hit = mvalid[idx] && (mtag[idx] == tag);
        beat_cyc = 0;

        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin check_output("req_ready_wait", 32'd0, 32'd1); return; end
        if (reset_beat < 0) exp_q.push_back(mem_word(addr));
        base = resp_count;
        drive_cyc = cyc;
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;

        if (hit) begin
            saw_mreq = 1'b0;
            n = 0;
            while (resp_count == base && n < 10) begin
                if (mem_req_valid) saw_mreq = 1'b1;
                tick();
                n++;
            end
            check_output("hit_no_refill", {31'b0, saw_mreq}, 32'd0);
            if (resp_count == base) begin check_output("hit_resp_timeout", 32'd0, 32'd1); return; end
            check_output("hit_latency", resp_cyc - drive_cyc, 32'd2);
            return;
        end

        n = 0;
        while (!mem_req_valid && n < 10) begin tick(); n++; end
        if (!mem_req_valid) begin check_output("mem_req_timeout", 32'd0, 32'd1); return; end
        check_output("mem_req_addr", mem_req_addr, line_addr);
        ok = 1'b1;
        for (int i = 0; i < req_stall; i++) begin
            tick();
            if (!mem_req_valid || mem_req_addr !== line_addr) ok = 1'b0;
        end
        if (req_stall > 0) check_output("mem_req_hold", {31'b0, ok}, 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_output("mem_req_release", {31'b0, mem_req_valid}, 32'd0);

        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 1)) begin
                mem_resp_data = $urandom;
                tick();
            end
`ifdef GELATO_ICACHE_FLUSH_EN
            if (b == flush_beat) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
`endif
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(line_addr + 32'(4 * b));
            if (b == stall_beat) begin
                rdy = 1'b0;
                repeat (3) tick();
                rdy = 1'b1;
            end
            beat_cyc = cyc;
            tick();
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (b == reset_beat) begin
                rst_n = 1'b0;
                tick();
                check_reset_values();
                rst_n = 1'b1;
                for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hDEAD_BEEF;
                repeat (2) tick();
                mem_resp_valid = 1'b0;
                tick();
                return;
            end
        end

        n = 0;
        while (resp_count == base && n < 20) begin tick(); n++; end
        if (resp_count == base) begin check_output("miss_resp_timeout", 32'd0, 32'd1); return; end
        check_output("miss_latency", resp_cyc - beat_cyc, 32'd2);
        mvalid[idx] = 1'b1;
        mtag[idx]   = tag;
        if (flush_beat >= 0) begin
            for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int stall_beat;
        rst_n = 1'b0;
        rdy = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
`ifdef GELATO_ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
        for (int i = 0; i < 64; i++) begin mvalid[i] = 1'b0; mtag[i] = 0; end
        for (int i = 0; i < 4; i++) begin
            mem_store[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
            mem_store[32'h500 + 32'(4 * i)] = 32'hB0 + 32'(i);
        end

        repeat (3) tick();
        check_reset_values();
        rst_n = 1'b1;
        tick();

        $display("[TB] cold miss, hit, conflict eviction");
        apply_stimulus(32'h0000_0104, 0, -1, -1, -1);
        apply_stimulus(32'h0000_010C, 0, -1, -1, -1);
        apply_stimulus(32'h0000_0500, 0, -1, -1, -1);
        apply_stimulus(32'h0000_0104, 0, -1, -1, -1);

        $display("[TB] backpressure and rdy stall");
        apply_stimulus(32'h0000_2008, 5, 2, -1, -1);

        $display("[TB] reset during refill");
        apply_stimulus(32'h0000_3048, 0, -1, 1, -1);
        apply_stimulus(32'h0000_3048, 0, -1, -1, -1);
        apply_stimulus(32'h0000_3044, 0, -1, -1, -1);

`ifdef GELATO_ICACHE_FLUSH_EN
        $display("[TB] deferred flush");
        apply_stimulus(32'h0000_010C, 0, -1, -1, -1);
        apply_stimulus(32'h0000_4000, 0, -1, -1, 1);
        apply_stimulus(32'h0000_010C, 0, -1, -1, -1);
`endif

        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            stall_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            apply_stimulus(a, int'($urandom_range(0, 2)), stall_beat, -1, -1);
        end

        repeat (5) tick();
        check_output("queue_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
